// File: rtl/alu_pkg.sv
// Shared encodings for the ALU core: opcodes, flag bit positions and FSM states.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_SHL = 4'd4,
      OP_SHR = 4'd5,
      OP_DEC = 4'd6,
      OP_INC = 4'd7,
      OP_XOR = 4'd8,
      OP_CMP = 4'd9,
      OP_ADC = 4'd10,
      OP_SBB = 4'd11,
      OP_MUL = 4'd12
   } alu_op_e;

   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 2;
   localparam int FLAG_S = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [WIDTH-1:0]   mplier_q;
   logic [CW-1:0]      cnt_q;
   logic               run_q;

   // done and product are presented combinationally during the final iteration
   assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign done    = run_q && (cnt_q == CW'(WIDTH - 1));
   assign product = acc_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else if (start) begin
         mcand_q  <= {{WIDTH{1'b0}}, a};
         acc_q    <= '0;
         mplier_q <= b;
         cnt_q    <= '0;
         run_q    <= 1'b1;
      end else if (run_q) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CW'(1);
         if (done) run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_core.sv
// Valid/ready ALU: single-cycle ops complete on the accept edge, MUL runs on alu_mul_seq.
module alu_core #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             busy
);

   import alu_pkg::*;

   localparam int M = WIDTH - 1;

   alu_state_e         state_q;
   logic [WIDTH-1:0]   result_q;
   logic [3:0]         flags_q;
   logic               out_valid_q;

   logic               accept;
   logic               mul_start;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_prod;
   logic [3:0]         mul_flg;

   logic [WIDTH-1:0]   b_sel;
   logic               cin;
   logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w;
   logic               add_v, sub_v;
   logic [WIDTH-1:0]   res_c;
   logic               c_c, v_c, z_c, s_c;
   logic [3:0]         flg_c;

   assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (op == OP_MUL);
   assign busy      = (state_q == ST_MUL);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_prod)
   );

   always_comb begin
      mul_flg         = '0;
      mul_flg[FLAG_Z] = (mul_prod[M:0] == '0);
      mul_flg[FLAG_C] = |mul_prod[2*WIDTH-1:WIDTH];
      mul_flg[FLAG_V] = |mul_prod[2*WIDTH-1:WIDTH];
      mul_flg[FLAG_S] = mul_prod[M];
   end

   // Shared adder/subtractor; INC/DEC reuse it with an operand of 1
   always_comb begin
      b_sel = ((op == OP_INC) || (op == OP_DEC)) ? WIDTH'(1) : b;
      cin   = ((op == OP_ADC) || (op == OP_SBB)) ? flags_q[FLAG_C] : 1'b0;
      add_w = {1'b0, a} + {1'b0, b_sel} + {{WIDTH{1'b0}}, cin};
      sub_w = {1'b0, a} - {1'b0, b_sel} - {{WIDTH{1'b0}}, cin};
      add_v = (a[M] == b_sel[M]) && (add_w[M] != a[M]);
      sub_v = (a[M] != b_sel[M]) && (sub_w[M] != a[M]);
      // One guard bit catches the last bit shifted out; large amounts shift to zero
      shl_w = {1'b0, a} << b[SHW-1:0];
      shr_w = {a, 1'b0} >> b[SHW-1:0];

      res_c = '0;
      c_c   = 1'b0;
      v_c   = 1'b0;
      case (op)
         OP_ADD, OP_ADC, OP_INC: begin
            res_c = add_w[M:0];
            c_c   = add_w[WIDTH];
            v_c   = add_v;
         end
         OP_SUB, OP_SBB, OP_DEC: begin
            res_c = sub_w[M:0];
            c_c   = sub_w[WIDTH];
            v_c   = sub_v;
         end
         OP_CMP: begin
            res_c = a;
            c_c   = sub_w[WIDTH];
            v_c   = sub_v;
         end
         OP_AND: res_c = a & b;
         OP_OR:  res_c = a | b;
         OP_XOR: res_c = a ^ b;
         OP_SHL: begin
            res_c = shl_w[M:0];
            c_c   = shl_w[WIDTH];
         end
         OP_SHR: begin
            res_c = shr_w[WIDTH:1];
            c_c   = shr_w[0];
         end
         default: ;
      endcase

      z_c = (res_c == '0);
      s_c = res_c[M];
      if (op == OP_CMP) begin
         z_c = (a == b);
         s_c = sub_w[M];
      end

      flg_c         = '0;
      flg_c[FLAG_Z] = z_c;
      flg_c[FLAG_C] = c_c;
      flg_c[FLAG_V] = v_c;
      flg_c[FLAG_S] = s_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         result_q    <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (out_valid_q && out_ready) out_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (op == OP_MUL) begin
                     state_q <= ST_MUL;
                  end else begin
                     result_q    <= res_c;
                     flags_q     <= flg_c;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               if (mul_done) begin
                  result_q    <= mul_prod[M:0];
                  flags_q     <= mul_flg;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning datapath width in bits (legal 4..32).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH)+1, meaning the number of low bits of b used as the shift amount.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready at a clk edge.
REQ-007 SHALL have port op  input  4  operation select.
REQ-008 SHALL have ports a, b  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result when out_valid && out_ready.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have port flags  output  4  registered status {S,V,C,Z}, bit0=Z, bit1=C, bit2=V, bit3=S.
REQ-013 SHALL have port busy  output  1  multi-cycle MUL in progress.

Function
REQ-014 SHALL decode op as: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR, 6 DEC(a), 7 INC(a), 8 XOR, 9 CMP, 10 ADC, 11 SBB, 12 MUL, 13-15 illegal.
REQ-015 SHALL use FSM states IDLE, MUL; IDLE->MUL on accepted op 12; MUL->IDLE after WIDTH iterations.
REQ-016 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-017 SHALL register single-cycle results and flags on the accept edge, asserting out_valid the following cycle: latency 1, throughput 1 op/cycle.
REQ-018 SHALL compute MUL by shift-add, one bit per cycle, asserting out_valid WIDTH+1 cycles after accept; busy is high in state MUL.
REQ-019 SHALL hold result, flags and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL clear out_valid on an out_ready handshake unless a new result is loaded on the same edge.
REQ-021 SHALL set Z = (result==0); for CMP, Z = (a==b) and result = a (no data change).
REQ-022 SHALL set C = carry-out for ADD/ADC/INC and borrow for SUB/SBB/DEC/CMP; ADC adds flags.C; SBB subtracts flags.C, using the flags register value at the accept edge.
REQ-023 SHALL set V = two's-complement signed overflow for arithmetic ops; for MUL, C = V = (upper WIDTH product bits != 0).
REQ-024 SHALL set S = MSB of result (CMP: MSB of a-b).
REQ-025 SHALL clear C and V for AND/OR/XOR.
REQ-026 SHALL, for SHL/SHR, shift by b[SHW-1:0] and return 0 when the amount is >= WIDTH; C = last bit shifted out, 0 for amount 0; V = 0.
REQ-027 SHALL wrap arithmetic modulo 2^WIDTH (e.g. INC of all-ones gives 0 with C=1).
REQ-028 SHALL make illegal ops return result 0, flags Z=1, C=V=S=0, with latency 1.
REQ-029 SHALL ignore in_valid while in_ready=0, with no side effects.

Reset
REQ-030 SHALL, while rst_n=0, force state IDLE, out_valid=0, result=0, flags=0, busy=0; in_ready=1 is permitted one cycle after deassertion.
REQ-031 SHALL, on reset asserted during MUL, discard the partial product and produce no out_valid.

Structure
REQ-032 SHALL place op encodings, flag bit indices (Z=0, C=1, V=2, S=3) and FSM state encodings in shared package alu_pkg.
REQ-033 SHALL isolate the iterative multiplier in one sub-module, alu_mul_seq (start, done, WIDTH-parameterised).

Verification
REQ-034 SHALL cover: WIDTH=8, ADD 0xFF+0x01 -> result 0x00, Z=1, C=1, V=0, out_valid 1 cycle after accept.
REQ-035 SHALL cover: ADD 0x7F+0x01, then ADC 0x00+0x00 back-to-back -> 0x80 with V=1, S=1, C=0; then 0x00 with Z=1.
REQ-036 SHALL cover: SUB 0x03-0x05 then SBB 0x10-0x00 -> 0xFE with C=1, S=1; then 0x0F.
REQ-037 SHALL cover: SHL 0x81 by 1 -> 0x02, C=1; SHR 0x81 by 9 -> 0x00, Z=1, C=0.
REQ-038 SHALL cover: MUL 0x10*0x10 with out_ready=0 for 3 cycles after out_valid -> result 0x00, C=V=1, Z=1; busy high 8 cycles; outputs stable until handshake; in_ready=0 throughout.
REQ-039 SHALL cover: rst_n pulsed low at MUL cycle 4 -> all outputs 0 immediately, no out_valid, next ADD 2+3 -> 0x05.
